// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receive byte buffer; edge-detects rx_done into a
//               circular FIFO with a first-word-fall-through read port.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam logic [ADDR_W:0]   c_FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] c_PTR_ONE  = ADDR_W'(1);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_rx_done_q;
  logic              r_overflow;

  logic w_wr_evt;
  logic w_rd_evt;
  logic w_wr_acc;
  logic w_drop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == c_FULL_CNT);
  assign rd_valid = ~empty;
  assign rd_data  = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign overflow = r_overflow;

  assign w_wr_evt = rx_done & ~r_rx_done_q;
  assign w_rd_evt = rd_valid & rd_ready;
  // A read in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_wr_acc = w_wr_evt & (~full | w_rd_evt);
  assign w_drop   = w_wr_evt & full & ~w_rd_evt;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= rx_data;
    end
  end

  // rx_done_q resets high so a level already present at release is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rx_done_q <= 1'b1;
      r_overflow  <= 1'b0;
    end else begin
      r_rx_done_q <= rx_done;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_evt) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_wr_acc && !w_rd_evt) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (w_rd_evt && !w_wr_acc) begin
        r_count <= r_count - c_CNT_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int c_DEPTH  = 16;
  localparam int c_ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_done = 1'b0;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [c_ADDR_W:0] count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              ovf_clr = 1'b0;

  uart_rx_fifo #(.DEPTH(c_DEPTH), .ADDR_W(c_ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, edge memory and sticky flag.
  logic [7:0] m_q[$];
  logic [7:0] drained[$];
  bit         m_done_q;
  bit         m_ovf;
  int         n_vec;
  int         n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("count", 32'(count), 32'(m_q.size()));
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("full", 32'(full), 32'(m_q.size() == c_DEPTH));
    check("rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() != 0) check("rd_data", 32'(rd_data), 32'(m_q[0]));
  endtask

  task automatic reset_model();
    m_q.delete();
    m_done_q = 1'b1;
    m_ovf    = 1'b0;
  endtask

  // Advance one clock, update the model from the inputs seen at the edge.
  task automatic tick();
    bit         rd, wr;
    logic [7:0] d;
    rd = (m_q.size() != 0) && rd_ready;
    wr = rx_done && !m_done_q;
    d  = rx_data;
    @(posedge clk);
    if (rd) drained.push_back(m_q.pop_front());
    if (wr) begin
      if (m_q.size() < c_DEPTH) m_q.push_back(d);
      else m_ovf = 1'b1;
    end else if (ovf_clr) begin
      m_ovf = 1'b0;
    end
    if (ovf_clr && !(wr && m_q.size() == c_DEPTH && !rd)) begin
      if (!(wr && !rd && m_q.size() == c_DEPTH)) m_ovf = m_ovf && wr && !rd && m_q.size() == c_DEPTH;
    end
    m_done_q = rx_done;
    #1;
    compare_all();
  endtask

  task automatic wr_byte(input logic [7:0] d);
    rx_data = d;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic drain_all();
    rd_ready = 1'b1;
    for (int i = 0; i < 2 * c_DEPTH && m_q.size() != 0; i++) tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_model();

    // Reset held with rx_done high; release must not create a byte.
    rst     = 1'b0;
    rx_done = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;
    tick();
    tick();
    check("no_write_after_release", 32'(count), 32'd0);
    rx_done = 1'b0;
    tick();

    // Single byte, then one read.
    wr_byte(8'h55);
    check("single_data", 32'(rd_data), 32'h55);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("single_empty", 32'(empty), 32'd1);

    // Long pulse gives exactly one entry.
    rx_data = 8'hA3;
    rx_done = 1'b1;
    repeat (3) tick();
    rx_done = 1'b0;
    tick();
    check("long_pulse_count", 32'(count), 32'd1);
    drain_all();

    // Fill, overflow, drain in order, clear.
    for (int i = 0; i < c_DEPTH; i++) wr_byte(8'(i));
    check("fill_full", 32'(full), 32'd1);
    wr_byte(8'hFF);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    drained.delete();
    drain_all();
    check("ovf_drain_len", 32'(drained.size()), 32'd16);
    for (int i = 0; i < drained.size(); i++) check("ovf_drain_order", 32'(drained[i]), 32'(i));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Full with simultaneous read and write.
    for (int i = 0; i < c_DEPTH; i++) wr_byte(8'(i));
    drained.delete();
    rx_data  = 8'h99;
    rx_done  = 1'b1;
    rd_ready = 1'b1;
    tick();
    rx_done  = 1'b0;
    rd_ready = 1'b0;
    check("rw_full_count", 32'(count), 32'd16);
    check("rw_full_ovf", 32'(overflow), 32'd0);
    check("rw_full_popped", 32'(drained[0]), 32'h00);
    drained.delete();
    drain_all();
    check("rw_drain_len", 32'(drained.size()), 32'd16);
    for (int i = 0; i < drained.size(); i++)
      check("rw_drain_order", 32'(drained[i]), (i < 15) ? 32'(i + 1) : 32'h99);

    // Wrap-around streaming.
    drained.delete();
    begin
      int wrote = 0;
      for (int cyc = 0; cyc < 400 && (wrote < 40 || m_q.size() != 0); cyc++) begin
        rd_ready = cyc[1];
        rx_done  = (cyc % 4 == 0) && (wrote < 40);
        rx_data  = 8'(8'h10 + wrote);
        if (rx_done) wrote++;
        tick();
      end
      rx_done  = 1'b0;
      rd_ready = 1'b0;
    end
    check("wrap_len", 32'(drained.size()), 32'd40);
    for (int i = 0; i < drained.size(); i++) check("wrap_order", 32'(drained[i]), 32'(8'h10 + i));

    // Randomized traffic.
    for (int cyc = 0; cyc < 600; cyc++) begin
      rx_data  = 8'($urandom);
      rx_done  = ($urandom_range(0, 2) == 0);
      rd_ready = ($urandom_range(0, 3) == 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      tick();
    end
    rx_done = 1'b0;
    ovf_clr = 1'b0;

    // Asynchronous reset mid-operation discards everything immediately.
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr_byte(8'hC0 + 8'(i));
    #3;
    rst = 1'b0;
    #1;
    reset_model();
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    compare_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
